// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline control slice
//
// Purpose: hazard sequencer state encoding, the per-stage control bundle width
// and the NOP/bubble values that the IF/ID, ID/EX, EX/MEM and MEM/WB stage
// registers load when flushed or bubbled.
// Ports: none (package).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int CTRL_W = 24;

  // A bubble is an all-zero control bundle: no register write, no memory access.
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  // sll $0,$0,0 encodes as all zeros, so a flushed IF/ID holds a real NOP.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detector
//
// Purpose: flags an ID instruction that needs the result of a load still in EX.
// Ports:
//   id_rs, id_rt  source register fields of the instruction in ID
//   id_uses_rt    ID instruction actually reads rt
//   ex_mem_read   instruction in EX is a load
//   ex_rd         destination of the instruction in EX
//   load_use      hazard present this cycle
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  // $0 is hardwired, so a load targeting it never produces a dependency.
  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: drives write enables and bubble/flush controls of PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB from load-use hazards, taken branches and a multi-cycle
// data memory; includes a memory-timeout watchdog and a stall-cycle counter.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rt, ex_mem_read/ex_rd   load-use detection inputs
//   branch_taken        branch resolved taken in EX
//   mem_req, mem_ready  data memory request / completion
//   pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we,
//   mem_wb_bubble       combinational pipeline controls
//   mem_err             sticky timeout flag (registered)
//   stall_cycles        saturating count of cycles with pc_we low (registered)
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CTRL_W      = pipe_ctrl_pkg::CTRL_W,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  // The stage registers size their bubble from the package, so an override
  // that disagrees with it would silently truncate or pad the bundle.
  if ((MEM_TIMEOUT < 1) || (MEM_TIMEOUT > 255) || (CTRL_W != pipe_ctrl_pkg::CTRL_W)) begin : g_param_check
    $error("pipeline_hazard_ctrl: illegal MEM_TIMEOUT or CTRL_W");
  end

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       load_use;
  logic       mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      wcnt         <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state_nxt == ERROR) begin
        mem_err <= 1'b1;
      end
      if (!pc_we && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    wcnt_nxt      = wcnt;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;

    // The MEM_WAIT cycle that sees mem_ready falls through to the RUN rules.
    mem_stall = ((state == RUN) && mem_req && !mem_ready) ||
                ((state == MEM_WAIT) && !mem_ready);

    // During reset the defaults stand so the stage registers reset themselves.
    if (!reset) begin
      if ((state == ERROR) || mem_stall) begin
        pc_we         = 1'b0;
        if_id_we      = 1'b0;
        id_ex_we      = 1'b0;
        ex_mem_we     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (branch_taken) begin
        // ID is squashed anyway, so a coincident load-use is irrelevant.
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == TIMEOUT) begin
          state_nxt = ERROR;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = RUN;
        wcnt_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  // Control vector order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble
  localparam logic [6:0] C_DEF = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;

  typedef struct packed {
    logic       reset;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       branch;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  typedef struct packed {
    logic [6:0]    ctrl;
    logic          err;
    logic [CW-1:0] stalls;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;
  logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble;
  logic          mem_err;
  logic [CW-1:0] stall_cycles;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_rd         (ex_rd),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .pc_we         (pc_we),
    .if_id_we      (if_id_we),
    .if_id_flush   (if_id_flush),
    .id_ex_we      (id_ex_we),
    .id_ex_bubble  (id_ex_bubble),
    .ex_mem_we     (ex_mem_we),
    .mem_wb_bubble (mem_wb_bubble),
    .mem_err       (mem_err),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: how many cycles the current access has waited (0 = none),
  // whether the watchdog has fired, and the total stalled cycles.
  int m_wait   = 0;
  bit m_err    = 1'b0;
  int m_stalls = 0;

  task automatic step(input stim_t s);
    logic [6:0] c;
    bit         lu;
    exp_t       e;
    @(posedge clk);
    #1;
    reset        = s.reset;
    id_rs        = s.rs;
    id_rt        = s.rt;
    id_uses_rt   = s.uses_rt;
    ex_mem_read  = s.ex_mem_read;
    ex_rd        = s.ex_rd;
    branch_taken = s.branch;
    mem_req      = s.mem_req;
    mem_ready    = s.mem_ready;

    lu = s.ex_mem_read && (s.ex_rd != 0) &&
         ((s.ex_rd == s.rs) || (s.uses_rt && (s.ex_rd == s.rt)));
    if (s.reset)                                          c = C_DEF;
    else if (m_err)                                       c = C_FRZ;
    else if (!s.mem_ready && (m_wait > 0 || s.mem_req))   c = C_FRZ;
    else if (s.branch)                                    c = C_BR;
    else if (lu)                                          c = C_LU;
    else                                                  c = C_DEF;

    e.ctrl   = c;
    e.err    = m_err;
    e.stalls = m_stalls[CW-1:0];
    exp_q.push_back(e);

    if (s.reset) begin
      m_wait   = 0;
      m_err    = 1'b0;
      m_stalls = 0;
    end else begin
      if (c[6] == 1'b0) m_stalls = (m_stalls < SAT) ? m_stalls + 1 : SAT;
      if (!m_err) begin
        if (m_wait > 0) begin
          if (s.mem_ready)     m_wait = 0;
          else if (m_wait == TO) m_err = 1'b1;
          else                 m_wait = m_wait + 1;
        end else if (s.mem_req && !s.mem_ready) begin
          m_wait = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble};
      n_checks = n_checks + 3;
      if (got === e.ctrl) n_pass = n_pass + 1;
      else $display("FAIL ctrl t=%0t got=%b want=%b", $time, got, e.ctrl);
      if (mem_err === e.err) n_pass = n_pass + 1;
      else $display("FAIL mem_err t=%0t got=%b want=%b", $time, mem_err, e.err);
      if (stall_cycles === e.stalls) n_pass = n_pass + 1;
      else $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, stall_cycles, e.stalls);
    end
  end

  initial begin
    stim_t s;
    stim_t rst;
    rst = '0;
    rst.reset = 1'b1;

    reset = 1'b1;
    {id_rs, id_rt, ex_rd} = '0;
    {id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready} = '0;
    repeat (2) @(posedge clk);

    // Reset cycle itself: defaults with a freshly reset counter.
    step(rst);
    s = '0; step(s);

    // Load-use on rs, then the bubble reaches EX.
    s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8; step(s);
    s = '0; step(s); step(s);

    // Load-use through rt, $0 destination, and rt match with rt unused.
    s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 5'd9; s.rt = 5'd9; s.uses_rt = 1'b1; step(s);
    s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 5'd0; s.rs = 5'd0; step(s);
    s = '0; s.ex_mem_read = 1'b1; s.ex_rd = 5'd9; s.rt = 5'd9; s.uses_rt = 1'b0; step(s);
    step(rst);

    // Memory wait of three cycles, then zero-latency access.
    s = '0; s.mem_req = 1'b1; repeat (3) step(s);
    s.mem_ready = 1'b1; step(s);
    s = '0; s.mem_req = 1'b1; s.mem_ready = 1'b1; step(s);
    s = '0; step(s);
    step(rst);

    // Branch beats load-use; then the same under a memory stall.
    s = '0; s.branch = 1'b1; s.ex_mem_read = 1'b1; s.ex_rd = 5'd3; s.rs = 5'd3; step(s);
    s.mem_req = 1'b1; repeat (2) step(s);
    s.mem_ready = 1'b1; step(s);
    s = '0; step(s);
    step(rst);

    // Watchdog: hold off mem_ready past the limit, then let it arrive.
    s = '0; s.mem_req = 1'b1; repeat (TO + 3) step(s);
    s.mem_ready = 1'b1; repeat (3) step(s);
    step(rst);
    s = '0; repeat (2) step(s);

    // Reset in the middle of a wait.
    s = '0; s.mem_req = 1'b1; repeat (2) step(s);
    step(rst);
    s = '0; step(s);

    // Sustained stall saturates the counter.
    s = '0; s.mem_req = 1'b1; repeat (SAT + 8) step(s);
    step(rst);

    for (int i = 0; i < 3000; i++) begin
      s.reset       = ($urandom_range(0, 63) == 0);
      s.rs          = 5'($urandom_range(0, 3));
      s.rt          = 5'($urandom_range(0, 3));
      s.uses_rt     = 1'($urandom_range(0, 1));
      s.ex_mem_read = 1'($urandom_range(0, 1));
      s.ex_rd       = 5'($urandom_range(0, 3));
      s.branch      = ($urandom_range(0, 4) == 0);
      s.mem_req     = ($urandom_range(0, 3) == 0);
      s.mem_ready   = ($urandom_range(0, 2) != 0);
      step(s);
    end

    repeat (3) @(posedge clk);
    n_checks = n_checks + 1;
    if (exp_q.size() == 0) n_pass = n_pass + 1;
    else $display("FAIL drain left=%0d want=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
